// File: rtl/riscv_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Holds the FSM/owner enums and the latched transaction record.
package riscv_pkg;
   localparam int XLEN = 32;

   typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_e;
   typedef enum logic {OWN_IF, OWN_LS} arb_owner_e;

   localparam logic [3:0] FETCH_BYTE_EN = 4'hF;

   // Fields captured at grant time and replayed on the memory bus in ISSUE.
   typedef struct packed {
      logic            we;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
      logic [3:0]      byte_en;
   } mem_txn_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, LSU and memory handshakes seen by the arbiter.
// slave: arbiter side; master: requesters and memory side.
interface mem_port_arbiter_if;
   import riscv_pkg::*;

   logic            if_req, if_gnt, if_rvalid, if_err;
   logic [XLEN-1:0] if_addr, if_rdata;
   logic            ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
   logic [XLEN-1:0] ls_addr, ls_wdata, ls_rdata;
   logic [3:0]      ls_byte_en;
   logic            mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]      mem_byte_en;

   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_byte_en,
             mem_gnt, mem_rvalid, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid, ls_rdata,
             ls_err, mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en
   );

   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_byte_en,
             mem_gnt, mem_rvalid, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, if_err, ls_gnt, ls_rvalid, ls_rdata,
             ls_err, mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en
   );
endinterface

// File: rtl/mem_port_arbiter_prio_select.sv
// Fixed LSU priority with a starvation override for fetch.
// Purely combinational; grants are mutually exclusive.
module arb_prio_select #(
   parameter int STARVE_LIMIT = 4,
   parameter int SW           = $clog2(STARVE_LIMIT + 1)
) (
   input  logic          if_req,
   input  logic          ls_req,
   input  logic [SW-1:0] starve_cnt,
   output logic          grant_if,
   output logic          grant_ls
);
   assign grant_if = if_req && (!ls_req || (starve_cnt == SW'(STARVE_LIMIT)));
   assign grant_ls = ls_req && !grant_if;
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing the data-memory port between fetch and LSU.
// A hung memory is converted into an error response after MAX_WAIT cycles.
module mem_port_arbiter
   import riscv_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int MAX_WAIT     = 255
) (
   input  logic             clk,
   input  logic             reset,
   mem_port_arbiter_if.slave bus
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int WW = $clog2(MAX_WAIT + 1);

   arb_state_e    r_state, w_next;
   arb_owner_e    r_owner;
   logic [SW-1:0] r_starve;
   logic [WW-1:0] r_wait;
   mem_txn_t      r_txn;

   logic w_sel_if, w_sel_ls, w_if_gnt, w_ls_gnt, w_issue, w_in_wait;
   logic w_rsp, w_rsp_err, w_timeout;

   arb_prio_select #(.STARVE_LIMIT(STARVE_LIMIT), .SW(SW)) u_sel (
      .if_req     (bus.if_req),
      .ls_req     (bus.ls_req),
      .starve_cnt (r_starve),
      .grant_if   (w_sel_if),
      .grant_ls   (w_sel_ls)
   );

   // Reset gates every output so nothing leaks during the reset cycle.
   assign w_if_gnt  = (r_state == ARB_IDLE) && !reset && w_sel_if;
   assign w_ls_gnt  = (r_state == ARB_IDLE) && !reset && w_sel_ls;
   assign w_issue   = (r_state == ARB_ISSUE) && !reset;
   assign w_in_wait = (r_state == ARB_WAIT) && !reset;
   assign w_timeout = (r_wait == WW'(MAX_WAIT - 1));
   assign w_rsp     = w_in_wait && (bus.mem_rvalid || w_timeout);
   assign w_rsp_err = !bus.mem_rvalid;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ARB_IDLE:  if (w_sel_if || w_sel_ls) w_next = ARB_ISSUE;
         ARB_ISSUE: if (bus.mem_gnt)          w_next = ARB_WAIT;
         ARB_WAIT:  if (bus.mem_rvalid || w_timeout) w_next = ARB_IDLE;
         default:   w_next = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ARB_IDLE;
         r_owner  <= OWN_IF;
         r_starve <= '0;
         r_wait   <= '0;
         r_txn    <= '0;
      end else begin
         r_state <= w_next;
         if (w_if_gnt) begin
            r_owner  <= OWN_IF;
            r_txn    <= '{we: 1'b0, addr: bus.if_addr, wdata: '0, byte_en: FETCH_BYTE_EN};
            r_starve <= '0;
         end else if (w_ls_gnt) begin
            r_owner <= OWN_LS;
            r_txn   <= '{we: bus.ls_we, addr: bus.ls_addr, wdata: bus.ls_wdata,
                         byte_en: bus.ls_byte_en};
            // Count LSU wins only while fetch is actually waiting; saturate at the limit.
            if (!bus.if_req)                         r_starve <= '0;
            else if (r_starve != SW'(STARVE_LIMIT))  r_starve <= r_starve + SW'(1);
         end
         if (w_issue && bus.mem_gnt) r_wait <= '0;
         else if (w_in_wait)         r_wait <= r_wait + WW'(1);
      end
   end

   assign bus.if_gnt      = w_if_gnt;
   assign bus.ls_gnt      = w_ls_gnt;
   assign bus.mem_req     = w_issue;
   assign bus.mem_we      = w_issue && r_txn.we;
   assign bus.mem_addr    = w_issue ? r_txn.addr    : '0;
   assign bus.mem_wdata   = w_issue ? r_txn.wdata   : '0;
   assign bus.mem_byte_en = w_issue ? r_txn.byte_en : '0;

   assign bus.if_rvalid = w_rsp && (r_owner == OWN_IF);
   assign bus.if_err    = bus.if_rvalid && w_rsp_err;
   assign bus.if_rdata  = (bus.if_rvalid && !w_rsp_err) ? bus.mem_rdata : '0;
   assign bus.ls_rvalid = w_rsp && (r_owner == OWN_LS);
   assign bus.ls_err    = bus.ls_rvalid && w_rsp_err;
   assign bus.ls_rdata  = (bus.ls_rvalid && !w_rsp_err) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected grants/responses,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_port_arbiter;
   import riscv_pkg::*;

   typedef struct packed {
      arb_owner_e  own;
      logic [31:0] data;
      logic        err;
   } rsp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   rsp_t       rsp_q[$];
   arb_owner_e gnt_q[$];

   always #5 clk = ~clk;

   mem_port_arbiter_if bus();

   mem_port_arbiter #(.STARVE_LIMIT(4), .MAX_WAIT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: any grant or response the DUT shows must match the head of its queue.
   always @(negedge clk) begin
      rsp_t       r;
      arb_owner_e g;
      if (bus.if_gnt || bus.ls_gnt) begin
         if (gnt_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_gnt: if_gnt=%b ls_gnt=%b with no grant pending",
                     bus.if_gnt, bus.ls_gnt);
         end else begin
            g = gnt_q.pop_front();
            chk("gnt_owner", {30'd0, bus.if_gnt, bus.ls_gnt}, (g == OWN_LS) ? 32'd1 : 32'd2);
         end
      end
      if (bus.if_rvalid || bus.ls_rvalid) begin
         if (rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid: if_rvalid=%b ls_rvalid=%b with no response pending",
                     bus.if_rvalid, bus.ls_rvalid);
         end else begin
            r = rsp_q.pop_front();
            chk("rsp_owner", {30'd0, bus.if_rvalid, bus.ls_rvalid},
                (r.own == OWN_LS) ? 32'd1 : 32'd2);
            chk("rsp_rdata", bus.if_rvalid ? bus.if_rdata : bus.ls_rdata, r.data);
            chk("rsp_err", {31'd0, bus.if_rvalid ? bus.if_err : bus.ls_err}, {31'd0, r.err});
         end
      end
      if (!bus.if_rvalid) chk("if_quiet", bus.if_rdata | {31'd0, bus.if_err}, 32'd0);
      if (!bus.ls_rvalid) chk("ls_quiet", bus.ls_rdata | {31'd0, bus.ls_err}, 32'd0);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      arb_owner_e ord [6];
      ord = '{OWN_LS, OWN_LS, OWN_LS, OWN_LS, OWN_IF, OWN_LS};

      reset = 1'b1;
      bus.if_req = 1'b1;      bus.if_addr = 32'h0;
      bus.ls_req = 1'b1;      bus.ls_we = 1'b0;   bus.ls_addr = 32'h0;
      bus.ls_wdata = 32'h0;   bus.ls_byte_en = 4'h0;
      bus.mem_gnt = 1'b0;     bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;

      // Reset state: requests present but nothing must be granted or driven.
      repeat (2) begin
         tick();
         @(negedge clk);
         chk("rst_gnt", {30'd0, bus.if_gnt, bus.ls_gnt}, 32'd0);
         chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
         chk("rst_mem_addr", bus.mem_addr, 32'd0);
      end
      tick();
      reset = 1'b0; bus.if_req = 1'b0; bus.ls_req = 1'b0;

      // Lone LSU read.
      tick();
      bus.ls_req = 1'b1; bus.ls_addr = 32'h100; gnt_q.push_back(OWN_LS);
      @(negedge clk);
      chk("t1_ls_gnt_c0", {31'd0, bus.ls_gnt}, 32'd1);
      chk("t1_mem_req_c0", {31'd0, bus.mem_req}, 32'd0);
      tick();
      bus.ls_req = 1'b0; bus.mem_gnt = 1'b1;
      @(negedge clk);
      chk("t1_mem_req_c1", {31'd0, bus.mem_req}, 32'd1);
      chk("t1_mem_addr", bus.mem_addr, 32'h100);
      chk("t1_mem_we", {31'd0, bus.mem_we}, 32'd0);
      tick();
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
      rsp_q.push_back('{OWN_LS, 32'hDEADBEEF, 1'b0});
      @(negedge clk);
      chk("t1_mem_req_c2", {31'd0, bus.mem_req}, 32'd0);
      chk("t1_ls_rvalid_c2", {31'd0, bus.ls_rvalid}, 32'd1);
      chk("t1_if_rvalid_c2", {31'd0, bus.if_rvalid}, 32'd0);
      tick();
      bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;

      // Both requesting continuously: LS x4, then fetch forced, then LS again.
      bus.if_req = 1'b1; bus.if_addr = 32'h1000;
      bus.ls_req = 1'b1; bus.ls_addr = 32'h200;
      for (int k = 0; k < 6; k++) begin
         gnt_q.push_back(ord[k]);
         tick();
         bus.mem_gnt = 1'b1;
         tick();
         bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA000_0000 + k;
         rsp_q.push_back('{ord[k], 32'hA000_0000 + k, 1'b0});
         tick();
         bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
      end
      bus.if_req = 1'b0; bus.ls_req = 1'b0;

      // LSU write with memory grant delayed; source fields change after grant.
      tick();
      bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 32'h300;
      bus.ls_wdata = 32'h12345678; bus.ls_byte_en = 4'b0011;
      gnt_q.push_back(OWN_LS);
      tick();
      bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_wdata = 32'hFFFF_FFFF; bus.ls_byte_en = 4'hC;
      for (int c = 1; c <= 3; c++) begin
         if (c == 2) begin bus.if_req = 1'b1; bus.if_addr = 32'h2000; end
         if (c == 3) bus.mem_gnt = 1'b1;
         @(negedge clk);
         chk("t3_mem_req", {31'd0, bus.mem_req}, 32'd1);
         chk("t3_mem_wdata", bus.mem_wdata, 32'h12345678);
         chk("t3_mem_byte_en", {28'd0, bus.mem_byte_en}, 32'h3);
         chk("t3_mem_we", {31'd0, bus.mem_we}, 32'd1);
         tick();
      end
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555AAAA;
      rsp_q.push_back('{OWN_LS, 32'h5555AAAA, 1'b0});
      @(negedge clk);
      chk("t3_mem_req_done", {31'd0, bus.mem_req}, 32'd0);
      chk("t3_busy_no_if_gnt", {31'd0, bus.if_gnt}, 32'd0);
      tick();

      // Fetch that was waiting is granted now; memory then never answers.
      bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
      gnt_q.push_back(OWN_IF);
      @(negedge clk);
      chk("t4_if_gnt", {31'd0, bus.if_gnt}, 32'd1);
      tick();
      bus.if_req = 1'b0; bus.mem_gnt = 1'b1;
      @(negedge clk);
      chk("t4_fetch_byte_en", {28'd0, bus.mem_byte_en}, 32'hF);
      chk("t4_fetch_we", {31'd0, bus.mem_we}, 32'd0);
      chk("t4_fetch_addr", bus.mem_addr, 32'h2000);
      tick();
      bus.mem_gnt = 1'b0;
      for (int w = 0; w < 7; w++) begin
         @(negedge clk);
         chk("t4_no_early_rvalid", {31'd0, bus.if_rvalid}, 32'd0);
         tick();
      end
      rsp_q.push_back('{OWN_IF, 32'h0, 1'b1});
      @(negedge clk);
      chk("t4_timeout_rvalid", {31'd0, bus.if_rvalid}, 32'd1);
      chk("t4_timeout_err", {31'd0, bus.if_err}, 32'd1);
      tick();
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD;
      @(negedge clk);
      chk("t4_stray_ignored", {30'd0, bus.if_rvalid, bus.ls_rvalid}, 32'd0);
      tick();
      bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;

      // Reset while an LSU read is outstanding in WAIT.
      bus.ls_req = 1'b1; bus.ls_addr = 32'h400; gnt_q.push_back(OWN_LS);
      tick();
      bus.ls_req = 1'b0; bus.mem_gnt = 1'b1;
      tick();
      bus.mem_gnt = 1'b0;
      tick();
      reset = 1'b1; bus.if_req = 1'b1; bus.if_addr = 32'h500;
      @(negedge clk);
      chk("t5_rst_gnt", {30'd0, bus.if_gnt, bus.ls_gnt}, 32'd0);
      chk("t5_rst_rvalid", {30'd0, bus.if_rvalid, bus.ls_rvalid}, 32'd0);
      chk("t5_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      tick();
      reset = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h77;
      gnt_q.push_back(OWN_IF);
      @(negedge clk);
      chk("t5_no_ls_rvalid", {31'd0, bus.ls_rvalid}, 32'd0);
      chk("t5_if_gnt_after_rst", {31'd0, bus.if_gnt}, 32'd1);
      tick();
      bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0; bus.if_req = 1'b0; bus.mem_gnt = 1'b1;
      @(negedge clk);
      chk("t5_fetch_addr", bus.mem_addr, 32'h500);
      tick();
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h600D;
      rsp_q.push_back('{OWN_IF, 32'h600D, 1'b0});
      tick();
      bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
      tick();

      chk("gnt_q_drained", gnt_q.size(), 32'd0);
      chk("rsp_q_drained", rsp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
